cache_ctrl: RTL and testbench

Read-request controller for the 8-way, 1024-line BDI data cache. It accepts word reads from the core and runs the tag lookup through the cache read channel. On a miss it fetches the 8-word line from memory, picks a victim way per set by round-robin, and writes the refilled line through the cache write channel. After reset it sweeps the whole array to invalid before it accepts any request.

---
 rtl/cache_ctrl_if.sv | 62 ++++++
 rtl/cache_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cache_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// Bus bundle for cache_ctrl: core request/response, cache read/write channels,
// line-fetch memory port and performance counters.
interface cache_ctrl_if;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned TAG_W   = 20;
    localparam int unsigned SET_W   = 7;
    localparam int unsigned OFF_W   = 3;
    localparam int unsigned IDX_W   = 10;
    localparam int unsigned WR_W    = 277;
    localparam int unsigned CNT_W   = 32;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [WORD_W-1:0] resp_data;

    logic              cache_op_read;
    logic [SET_W-1:0]  cache_read_index;
    logic [TAG_W-1:0]  cache_read_tag;
    logic [OFF_W-1:0]  cache_read_word_addr;
    logic              cache_read_hit;
    logic [WORD_W-1:0] cache_read_word_data;

    logic [WR_W-1:0]   cache_write_data;
    logic [IDX_W-1:0]  cache_write_index;
    logic              cache_write_on_demand;
    logic              cache_write_word_valid;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [WORD_W-1:0] mem_rsp_data;

    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  req_valid, req_addr, resp_ready,
        input  cache_read_hit, cache_read_word_data,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, resp_valid, resp_data,
        output cache_op_read, cache_read_index, cache_read_tag, cache_read_word_addr,
        output cache_write_data, cache_write_index, cache_write_on_demand, cache_write_word_valid,
        output mem_req_valid, mem_req_addr,
        output hit_count, miss_count
    );

    modport slave (
        output req_valid, req_addr, resp_ready,
        output cache_read_hit, cache_read_word_data,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, resp_valid, resp_data,
        input  cache_op_read, cache_read_index, cache_read_tag, cache_read_word_addr,
        input  cache_write_data, cache_write_index, cache_write_on_demand, cache_write_word_valid,
        input  mem_req_valid, mem_req_addr,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl.sv
// Read-request controller for the 8-way, 128-set data cache: init sweep, tag
// lookup, line refill from memory with per-set round-robin victim selection.
module cache_ctrl (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.master bus
);
    localparam int unsigned LINE_WORDS      = 8;
    localparam int unsigned TAG_FIELD       = 20;
    localparam int unsigned DATA_FIELD      = 32 * LINE_WORDS;
    localparam int unsigned CACHELINE_COUNT = 1024;
    localparam int unsigned SET_COUNT       = 128;
    localparam int unsigned SET_W           = 7;
    localparam int unsigned WAY_W           = 3;
    localparam int unsigned OFF_W           = 3;
    localparam int unsigned IDX_W           = 10;
    localparam int unsigned WR_W            = 1 + TAG_FIELD + DATA_FIELD;
    localparam int unsigned CNT_W           = 32;

    localparam logic [2:0] S_INIT       = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_LOOKUP     = 3'd2;
    localparam logic [2:0] S_MISS_REQ   = 3'd3;
    localparam logic [2:0] S_REFILL     = 3'd4;
    localparam logic [2:0] S_FILL_WRITE = 3'd5;
    localparam logic [2:0] S_RESPOND    = 3'd6;

    logic [2:0]            state_q, state_n;
    logic [IDX_W-1:0]      init_cnt_q, init_cnt_n;
    logic [TAG_FIELD-1:0]  tag_q, tag_n;
    logic [SET_W-1:0]      set_q, set_n;
    logic [OFF_W-1:0]      word_q, word_n;
    logic [OFF_W-1:0]      beat_q, beat_n;
    logic [DATA_FIELD-1:0] fill_buf_q, fill_buf_n;
    logic [WAY_W-1:0]      rr_ptr [SET_COUNT];
    logic                  rr_adv;

    logic                  req_ready_q, resp_valid_q, op_read_q, mem_req_valid_q;
    logic [31:0]           resp_data_q, resp_data_n;
    logic [WR_W-1:0]       wr_data_q, wr_data_n;
    logic [IDX_W-1:0]      wr_index_q, wr_index_n;
    logic                  wr_demand_q, wr_demand_n;
    logic                  wr_sweep_q, wr_sweep_n;
    logic [CNT_W-1:0]      hit_q, hit_n, miss_q, miss_n;

    // Byte offset is irrelevant for word reads.
    logic unused_byte_bits;
    assign unused_byte_bits = ^bus.req_addr[1:0];

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_n     = state_q;
        init_cnt_n  = init_cnt_q;
        tag_n       = tag_q;
        set_n       = set_q;
        word_n      = word_q;
        beat_n      = beat_q;
        fill_buf_n  = fill_buf_q;
        resp_data_n = resp_data_q;
        wr_data_n   = '0;
        wr_index_n  = '0;
        wr_demand_n = 1'b0;
        wr_sweep_n  = 1'b0;
        hit_n       = hit_q;
        miss_n      = miss_q;
        rr_adv      = 1'b0;
        case (state_q)
            S_INIT: begin
                // Leave once the strobe for the last line is on the bus.
                if (wr_sweep_q && (wr_index_q == IDX_W'(CACHELINE_COUNT - 1))) begin
                    state_n = S_IDLE;
                end else begin
                    wr_sweep_n = 1'b1;
                    wr_index_n = init_cnt_q;
                    init_cnt_n = init_cnt_q + IDX_W'(1);
                end
            end
            S_IDLE: begin
                if (bus.req_valid) begin
                    tag_n   = bus.req_addr[31:12];
                    set_n   = bus.req_addr[11:5];
                    word_n  = bus.req_addr[4:2];
                    state_n = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (bus.cache_read_hit) begin
                    resp_data_n = bus.cache_read_word_data;
                    if (hit_q != '1) hit_n = hit_q + CNT_W'(1);
                    state_n = S_RESPOND;
                end else begin
                    if (miss_q != '1) miss_n = miss_q + CNT_W'(1);
                    state_n = S_MISS_REQ;
                end
            end
            S_MISS_REQ: begin
                if (bus.mem_req_ready) begin
                    beat_n  = '0;
                    state_n = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.mem_rsp_valid) begin
                    fill_buf_n[{beat_q, 5'd0} +: 32] = bus.mem_rsp_data;
                    beat_n = beat_q + OFF_W'(1);
                    // The last beat goes straight into the write payload.
                    if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
                        wr_demand_n = 1'b1;
                        wr_index_n  = {rr_ptr[set_q], set_q};
                        wr_data_n   = {1'b1, tag_q, fill_buf_n};
                        state_n     = S_FILL_WRITE;
                    end
                end
            end
            S_FILL_WRITE: begin
                rr_adv      = 1'b1;
                resp_data_n = fill_buf_q[{word_q, 5'd0} +: 32];
                state_n     = S_RESPOND;
            end
            S_RESPOND: begin
                if (bus.resp_ready) state_n = S_IDLE;
            end
            default: state_n = S_INIT;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= S_INIT;
            init_cnt_q      <= '0;
            tag_q           <= '0;
            set_q           <= '0;
            word_q          <= '0;
            beat_q          <= '0;
            fill_buf_q      <= '0;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            op_read_q       <= 1'b0;
            mem_req_valid_q <= 1'b0;
            resp_data_q     <= '0;
            wr_data_q       <= '0;
            wr_index_q      <= '0;
            wr_demand_q     <= 1'b0;
            wr_sweep_q      <= 1'b0;
            hit_q           <= '0;
            miss_q          <= '0;
        end else begin
            state_q         <= state_n;
            init_cnt_q      <= init_cnt_n;
            tag_q           <= tag_n;
            set_q           <= set_n;
            word_q          <= word_n;
            beat_q          <= beat_n;
            fill_buf_q      <= fill_buf_n;
            req_ready_q     <= (state_n == S_IDLE);
            resp_valid_q    <= (state_n == S_RESPOND);
            op_read_q       <= (state_n == S_LOOKUP);
            mem_req_valid_q <= (state_n == S_MISS_REQ);
            resp_data_q     <= resp_data_n;
            wr_data_q       <= wr_data_n;
            wr_index_q      <= wr_index_n;
            wr_demand_q     <= wr_demand_n;
            wr_sweep_q      <= wr_sweep_n;
            hit_q           <= hit_n;
            miss_q          <= miss_n;
        end
    end

    // Per-set victim pointers; only a completed refill advances one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < SET_COUNT; i++) rr_ptr[i] <= '0;
        end else if (rr_adv) begin
            rr_ptr[set_q] <= rr_ptr[set_q] + WAY_W'(1);
        end
    end

    assign bus.req_ready              = req_ready_q;
    assign bus.resp_valid             = resp_valid_q;
    assign bus.resp_data              = resp_data_q;
    assign bus.cache_op_read          = op_read_q;
    assign bus.cache_read_index       = set_q;
    assign bus.cache_read_tag         = tag_q;
    assign bus.cache_read_word_addr   = word_q;
    assign bus.cache_write_data       = wr_data_q;
    assign bus.cache_write_index      = wr_index_q;
    assign bus.cache_write_on_demand  = wr_demand_q;
    assign bus.cache_write_word_valid = wr_sweep_q;
    assign bus.mem_req_valid          = mem_req_valid_q;
    assign bus.mem_req_addr           = {tag_q, set_q, 5'b0};
    assign bus.hit_count              = hit_q;
    assign bus.miss_count             = miss_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural cache array and a
// hand-driven memory port.
module tb_cache_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cache_ctrl_if bus ();
    cache_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural cache array written through the controller's write channel.
    logic [276:0] cmem [1024];
    always @(posedge clk) begin
        if (bus.cache_write_word_valid || bus.cache_write_on_demand)
            cmem[bus.cache_write_index] <= bus.cache_write_data;
    end

    logic         mdl_hit;
    logic [31:0]  mdl_word;
    logic [276:0] mdl_line;
    always_comb begin
        mdl_hit  = 1'b0;
        mdl_word = '0;
        mdl_line = '0;
        for (int w = 0; w < 8; w++) begin
            mdl_line = cmem[{3'(w), bus.cache_read_index}];
            if (mdl_line[276] === 1'b1 && mdl_line[275:256] === bus.cache_read_tag) begin
                mdl_hit  = 1'b1;
                mdl_word = mdl_line[{bus.cache_read_word_addr, 5'd0} +: 32];
            end
        end
    end
    assign bus.cache_read_hit       = mdl_hit;
    assign bus.cache_read_word_data = mdl_word;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input bit stray);
        int bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (stray) begin
                bus.mem_rsp_valid = 1'(i % 2);
                bus.mem_rsp_data  = 32'hDEAD_0000 | 32'(i);
            end
            tick();
            if (!(bus.cache_write_word_valid === 1'b1 && bus.cache_write_index === 10'(i) &&
                  bus.cache_write_data === 277'd0 && bus.cache_write_on_demand === 1'b0 &&
                  bus.req_ready === 1'b0))
                bad++;
        end
        bus.mem_rsp_valid = 1'b0;
        check("sweep_order", 288'(bad), 288'd0);
        tick();
        check("ready_after_sweep", 288'({bus.req_ready, bus.cache_write_word_valid}), 288'(2'b10));
    endtask

    task automatic do_miss(input logic [31:0] addr, input logic [31:0] beat_base,
                           input logic [9:0] exp_idx, input string tag);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        while (bus.mem_req_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_memreq"}, 288'({bus.mem_req_valid, bus.mem_req_addr}),
              288'({1'b1, addr[31:5], 5'b0}));
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = beat_base + 32'(b);
            tick();
        end
        bus.mem_rsp_valid = 1'b0;
        check({tag, "_widx"}, 288'({bus.cache_write_on_demand, bus.cache_write_index}),
              288'({1'b1, exp_idx}));
        tick();
        check({tag, "_resp"}, 288'({bus.resp_valid, bus.resp_data}),
              288'({1'b1, beat_base + 32'(addr[4:2])}));
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [276:0] exp_line;
        logic [9:0]   rr_exp [9];
        int           bad;

        rr_exp = '{10'h005, 10'h085, 10'h105, 10'h185, 10'h205, 10'h285, 10'h305, 10'h385, 10'h005};
        exp_line = {1'b1, 20'h00001,
                    256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0};

        rst = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        tick(); tick(); tick();
        check("reset_outputs", 288'({bus.req_ready, bus.resp_valid, bus.mem_req_valid, bus.cache_op_read,
                                     bus.cache_write_on_demand, bus.cache_write_word_valid}), 288'd0);
        check("reset_counters", 288'({bus.hit_count, bus.miss_count}), 288'd0);

        rst = 1'b1;
        run_sweep(1'b0);

        // Cold miss to 0x1024: set 1, tag 1, word 1.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_1024;
        tick();
        bus.req_valid = 1'b0;
        check("cold_lookup", 288'({bus.cache_op_read, bus.req_ready, bus.cache_read_index,
                                   bus.cache_read_tag, bus.cache_read_word_addr}),
              288'({1'b1, 1'b0, 7'h01, 20'h00001, 3'd1}));
        tick();
        check("cold_memreq", 288'({bus.mem_req_valid, bus.mem_req_addr}), 288'({1'b1, 32'h0000_1020}));
        check("cold_miss_count", 288'(bus.miss_count), 288'd1);
        tick();
        check("memreq_held", 288'(bus.mem_req_valid), 288'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("memreq_dropped", 288'(bus.mem_req_valid), 288'd0);
        for (int b = 0; b < 8; b++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hA0 + 32'(b);
            tick();
        end
        bus.mem_rsp_valid = 1'b0;
        check("cold_write_strobe", 288'({bus.cache_write_on_demand, bus.cache_write_word_valid,
                                         bus.cache_write_index}), 288'({2'b10, 10'h001}));
        check("cold_write_data", 288'(bus.cache_write_data), 288'(exp_line));
        tick();
        check("cold_resp", 288'({bus.resp_valid, bus.resp_data, bus.cache_write_on_demand}),
              288'({1'b1, 32'hA1, 1'b0}));
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("cold_done", 288'({bus.req_ready, bus.resp_valid}), 288'(2'b10));

        // Hit on word 7 of the refilled line.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_103C;
        tick();
        bus.req_valid = 1'b0;
        check("hit_lookup", 288'({bus.cache_op_read, bus.mem_req_valid}), 288'(2'b10));
        tick();
        check("hit_resp", 288'({bus.resp_valid, bus.resp_data, bus.mem_req_valid}),
              288'({1'b1, 32'hA7, 1'b0}));
        check("hit_count", 288'(bus.hit_count), 288'd1);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("hit_done", 288'(bus.req_ready), 288'd1);

        // Response backpressure on a hit to word 0.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_1020;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if (!(bus.resp_valid === 1'b1 && bus.resp_data === 32'hA0 && bus.req_ready === 1'b0)) bad++;
            tick();
        end
        check("bp_stable", 288'(bad), 288'd0);
        check("bp_still_held", 288'({bus.resp_valid, bus.resp_data}), 288'({1'b1, 32'hA0}));
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
        check("bp_release", 288'({bus.req_ready, bus.resp_valid}), 288'(2'b10));

        // Nine misses to set 5 walk every way, then wrap to way 0.
        for (int k = 0; k < 9; k++)
            do_miss((32'(16 + k) << 12) | 32'h0000_00A0, 32'hC000_0000 + 32'(k * 16), rr_exp[k],
                    $sformatf("rr%0d", k));
        check("counters_after_rr", 288'({bus.hit_count, bus.miss_count}), 288'({32'd2, 32'd10}));

        // Reset in the middle of a refill.
        bus.req_valid = 1'b1; bus.req_addr = 32'h0000_2044;
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = 32'hE0 + 32'(b);
            tick();
        end
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            bus.mem_rsp_data = 32'hE4 + 32'(k);
            tick();
            if ({bus.req_ready, bus.resp_valid, bus.mem_req_valid, bus.cache_op_read,
                 bus.cache_write_on_demand, bus.cache_write_word_valid} !== 6'd0) bad++;
        end
        check("midrst_quiet", 288'(bad), 288'd0);
        check("midrst_counters", 288'({bus.hit_count, bus.miss_count}), 288'd0);
        rst = 1'b1;
        run_sweep(1'b1);
        check("post_rst_counters", 288'({bus.hit_count, bus.miss_count}), 288'd0);
        do_miss(32'h0000_2044, 32'hB0, 10'h002, "after_rst");
        do_miss(32'h0001_00A0, 32'hD0, 10'h005, "rr_reset");
        check("final_counters", 288'({bus.hit_count, bus.miss_count}), 288'({32'd0, 32'd2}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
